// File: rtl/alu_sequencer_pkg.sv
// Shared opcodes, error bit indices, FSM state type and defaults for the ALU sequencer.
package alu_sequencer_pkg;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_MUL  = 4'd2;
  localparam logic [3:0] OP_DIV  = 4'd3;
  localparam logic [3:0] OP_MOD  = 4'd4;
  localparam logic [3:0] OP_AND  = 4'd5;
  localparam logic [3:0] OP_OR   = 4'd6;
  localparam logic [3:0] OP_NAND = 4'd7;
  localparam logic [3:0] OP_NOR  = 4'd8;
  localparam logic [3:0] OP_XOR  = 4'd9;
  localparam logic [3:0] OP_XNOR = 4'd10;
  localparam logic [3:0] OP_NOT  = 4'd11;
  localparam logic [3:0] OP_ONES = 4'd12;
  localparam logic [3:0] OP_ZERO = 4'd13;
  localparam logic [3:0] OP_PASS = 4'd14;
  localparam logic [3:0] OP_RSVD = 4'd15;

  localparam int ERR_OVF  = 0;
  localparam int ERR_DIV0 = 1;

  localparam int SETTLE_CYCLES_DEF = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RESP  = 2'd2
  } state_e;

  // Only errors meaningful to the opcode are reported; the reserved op always reports both.
  function automatic logic [1:0] qualify_err(input logic [3:0] op, input logic [1:0] err);
    logic [1:0] q;
    q = 2'b00;
    if (op == OP_RSVD) begin
      q = 2'b11;
    end else begin
      if (op == OP_ADD || op == OP_SUB) q[ERR_OVF]  = err[ERR_OVF];
      if (op == OP_DIV || op == OP_MOD) q[ERR_DIV0] = err[ERR_DIV0];
    end
    return q;
  endfunction

endpackage

// File: rtl/alu_sequencer_settle.sv
// Settle down-counter: loaded on command accept, flags the edge on which the ALU result is valid.
module settle_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         done
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load)               cnt_d = load_val;
    else if (cnt_q != '0)   cnt_d = cnt_q - W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  // A count of one means the current edge is the last settle edge.
  assign done = (cnt_q == W'(1));

endmodule

// File: rtl/alu_sequencer.sv
// Sequences single commands through an external combinational ALU and accumulates its result.
module alu_sequencer
  import alu_sequencer_pkg::*;
#(
  parameter int SETTLE_CYCLES = SETTLE_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [3:0]  cmd_op,
  input  logic [15:0] cmd_operand,
  output logic [15:0] alu_a,
  output logic [15:0] alu_b,
  output logic [3:0]  alu_op,
  input  logic [31:0] alu_result,
  input  logic [1:0]  alu_err,
  output logic [31:0] acc,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [1:0]  rsp_err,
  output logic [1:0]  sticky_err,
  input  logic        err_clear
);

  state_e      state_q, state_d;
  logic [15:0] alu_a_q, alu_a_d;
  logic [3:0]  alu_op_q, alu_op_d;
  logic [3:0]  op_q, op_d;
  logic [31:0] acc_q, acc_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [1:0]  rsp_err_q, rsp_err_d;
  logic [1:0]  sticky_q, sticky_d;
  logic [1:0]  qerr;
  logic        accept, capture, settle_done;

  settle_timer #(.W(4)) u_settle (
    .clk      (clk),
    .rst      (rst),
    .load     (accept),
    .load_val (4'(SETTLE_CYCLES)),
    .done     (settle_done)
  );

  assign accept  = (state_q == ST_IDLE) && cmd_valid;
  assign capture = (state_q == ST_ISSUE) && settle_done;
  assign qerr    = qualify_err(op_q, alu_err);

  always_comb begin
    state_d     = state_q;
    alu_a_d     = alu_a_q;
    alu_op_d    = alu_op_q;
    op_d        = op_q;
    acc_d       = acc_q;
    rsp_valid_d = rsp_valid_q;
    rsp_err_d   = rsp_err_q;
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          alu_a_d  = cmd_operand;
          alu_op_d = cmd_op;
          op_d     = cmd_op;
          state_d  = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (settle_done) begin
          state_d     = ST_RESP;
          rsp_valid_d = 1'b1;
          rsp_err_d   = qerr;
          // Divide-by-zero keeps the old accumulator; overflow still takes the wrapped result.
          if (!qerr[ERR_DIV0]) begin
            if (op_q <= OP_ONES)      acc_d = alu_result;
            else if (op_q == OP_ZERO) acc_d = '0;
          end
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          state_d     = ST_IDLE;
          rsp_valid_d = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // A clear coinciding with a capture still records the new error.
  always_comb begin
    sticky_d = sticky_q;
    if (capture)        sticky_d = (err_clear ? 2'b00 : sticky_q) | qerr;
    else if (err_clear) sticky_d = 2'b00;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      alu_a_q     <= '0;
      alu_op_q    <= '0;
      op_q        <= '0;
      acc_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= '0;
      sticky_q    <= '0;
    end else begin
      state_q     <= state_d;
      alu_a_q     <= alu_a_d;
      alu_op_q    <= alu_op_d;
      op_q        <= op_d;
      acc_q       <= acc_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      sticky_q    <= sticky_d;
    end
  end

  assign cmd_ready  = (state_q == ST_IDLE);
  assign alu_a      = alu_a_q;
  assign alu_b      = acc_q[15:0];
  assign alu_op     = alu_op_q;
  assign acc        = acc_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_err    = rsp_err_q;
  assign sticky_err = sticky_q;

endmodule
